// File: rtl/bs_pkg.sv
// rtl/bs_pkg.sv - shared state and shift-phase encodings for the boundary-scan master
package bs_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CAP_L  = 3'd1,
    CAP_H  = 3'd2,
    SHIFT  = 3'd3,
    UPDATE = 3'd4,
    DONE   = 3'd5
  } bs_state_t;

  // Each shifted bit spends one cycle in each phase; ClockBR follows the phase.
  localparam logic PH_LOW  = 1'b0;
  localparam logic PH_HIGH = 1'b1;

endpackage

// File: rtl/bs_scan_master.sv
// rtl/bs_scan_master.sv - capture/shift/update sequencer for a boundary-scan chain
module bs_scan_master
  import bs_pkg::*;
#(
  parameter int Length = 8
) (
  input  logic              Clock,
  input  logic              Rst,
  input  logic              Start,
  input  logic [Length-1:0] TxData,
  input  logic              ModeReq,
  input  logic              ScanIn,
  output logic              ScanOut,
  output logic              ShiftBR,
  output logic              ClockBR,
  output logic              UpdateBR,
  output logic              ModeControl,
  output logic [Length-1:0] RxData,
  output logic              Busy,
  output logic              Done
);

  localparam int CntW = $clog2(Length + 1);

  bs_state_t         state_q, state_d;
  logic              phase_q, phase_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [Length-1:0] tx_q, tx_d;
  logic [Length-1:0] rx_q, rx_d;
  logic              mode_d;

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      phase_q <= PH_LOW;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    mode_d  = ModeControl;
    case (state_q)
      IDLE: begin
        if (Start) begin
          tx_d    = TxData;
          mode_d  = ModeReq;
          state_d = CAP_L;
        end
      end
      CAP_L: state_d = CAP_H;
      CAP_H: begin
        state_d = SHIFT;
        phase_d = PH_LOW;
        cnt_d   = CntW'(Length - 1);
      end
      SHIFT: begin
        if (phase_q == PH_LOW) begin
          // Sample SOUT just before the ClockBR rise that shifts the chain.
          rx_d    = rx_q << 1;
          rx_d[0] = ScanIn;
          phase_d = PH_HIGH;
        end else begin
          tx_d    = tx_q << 1;
          phase_d = PH_LOW;
          if (cnt_q == '0) state_d = UPDATE;
          else             cnt_d   = cnt_q - CntW'(1);
        end
      end
      UPDATE:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Chain-facing outputs are decoded from the next state and registered so they never glitch.
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      ScanOut     <= 1'b0;
      ShiftBR     <= 1'b0;
      ClockBR     <= 1'b0;
      UpdateBR    <= 1'b0;
      ModeControl <= 1'b0;
      RxData      <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
    end else begin
      ShiftBR     <= (state_d == SHIFT);
      ClockBR     <= (state_d == CAP_H) || ((state_d == SHIFT) && (phase_d == PH_HIGH));
      UpdateBR    <= (state_d == UPDATE);
      ScanOut     <= (state_d == SHIFT) ? tx_d[Length-1] : 1'b0;
      ModeControl <= mode_d;
      Busy        <= (state_d != IDLE);
      Done        <= (state_d == DONE);
      if (state_d == DONE) RxData <= rx_q;
    end
  end

endmodule

// File: tb/tb_bs_scan_master.sv
// tb/tb_bs_scan_master.sv - scoreboard bench driving three chain lengths through bs_scan_master
module tb_bs_scan_master;

  logic Clock = 1'b0;
  logic Rst;
  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;
  int sel = 8;
  logic [7:0] sb[$];
  int rises, upds, busys, so_bad, dones, dcyc;
  logic [7:0] saved;
  int idle_busy;

  logic start4 = 1'b0, mreq4 = 1'b0, si4, so4, sh4, ck4, up4, mc4, busy4, done4;
  logic [3:0] tx4 = '0, rx4, din4, cell4 = '0, dout4 = '0;
  logic start8 = 1'b0, mreq8 = 1'b0, si8, so8, sh8, ck8, up8, mc8, busy8, done8;
  logic [7:0] tx8 = '0, rx8, din8, cell8 = '0, dout8 = '0;
  logic start1 = 1'b0, mreq1 = 1'b0, si1, so1, sh1, ck1, up1, mc1, busy1, done1;
  logic [0:0] tx1 = '0, rx1, din1, cell1 = '0, dout1 = '0;

  bs_scan_master #(.Length(4)) u4 (.Clock(Clock), .Rst(Rst), .Start(start4), .TxData(tx4),
    .ModeReq(mreq4), .ScanIn(si4), .ScanOut(so4), .ShiftBR(sh4), .ClockBR(ck4), .UpdateBR(up4),
    .ModeControl(mc4), .RxData(rx4), .Busy(busy4), .Done(done4));
  bs_scan_master #(.Length(8)) u8 (.Clock(Clock), .Rst(Rst), .Start(start8), .TxData(tx8),
    .ModeReq(mreq8), .ScanIn(si8), .ScanOut(so8), .ShiftBR(sh8), .ClockBR(ck8), .UpdateBR(up8),
    .ModeControl(mc8), .RxData(rx8), .Busy(busy8), .Done(done8));
  bs_scan_master #(.Length(1)) u1 (.Clock(Clock), .Rst(Rst), .Start(start1), .TxData(tx1),
    .ModeReq(mreq1), .ScanIn(si1), .ScanOut(so1), .ShiftBR(sh1), .ClockBR(ck1), .UpdateBR(up1),
    .ModeControl(mc1), .RxData(rx1), .Busy(busy1), .Done(done1));

  // Boundary-scan chain models: SIN enters cell 0, SOUT is the top cell.
  always @(posedge ck4) cell4 <= sh4 ? {cell4[2:0], so4} : din4;
  always @(posedge up4) dout4 <= cell4;
  assign si4 = cell4[3];
  always @(posedge ck8) cell8 <= sh8 ? {cell8[6:0], so8} : din8;
  always @(posedge up8) dout8 <= cell8;
  assign si8 = cell8[7];
  always @(posedge ck1) cell1 <= sh1 ? so1 : din1;
  always @(posedge up1) dout1 <= cell1;
  assign si1 = cell1;

  logic done_s, busy_s, ck_s, up_s, sh_s, so_s, mc_s;
  logic [7:0] rx_s, dout_s;
  always_comb begin
    done_s = done8; busy_s = busy8; ck_s = ck8; up_s = up8; sh_s = sh8; so_s = so8; mc_s = mc8;
    rx_s = rx8; dout_s = dout8;
    if (sel == 4) begin
      done_s = done4; busy_s = busy4; ck_s = ck4; up_s = up4; sh_s = sh4; so_s = so4; mc_s = mc4;
      rx_s = {4'h0, rx4}; dout_s = {4'h0, dout4};
    end else if (sel == 1) begin
      done_s = done1; busy_s = busy1; ck_s = ck1; up_s = up1; sh_s = sh1; so_s = so1; mc_s = mc1;
      rx_s = {7'h0, rx1}; dout_s = {7'h0, dout1};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    start4 = v && (sel == 4);
    start8 = v && (sel == 8);
    start1 = v && (sel == 1);
  endtask

  // Launches one operation on the selected instance and follows it until Done or a cycle budget.
  task automatic run_op(input logic [7:0] tx, input logic mode, input int stray);
    logic prev_ck;
    rises = 0; upds = 0; busys = 0; so_bad = 0; dones = 0; dcyc = 0;
    if (sel == 4) begin tx4 = tx[3:0]; mreq4 = mode; sb.push_back({4'h0, din4}); end
    else if (sel == 1) begin tx1 = tx[0]; mreq1 = mode; sb.push_back({7'h0, din1}); end
    else begin tx8 = tx; mreq8 = mode; sb.push_back(din8); end
    set_start(1'b1);
    @(negedge Clock);
    set_start(1'b0);
    prev_ck = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (ck_s && !prev_ck) rises++;
      prev_ck = ck_s;
      if (up_s) upds++;
      if (busy_s) busys++;
      if (!sh_s && so_s) so_bad++;
      set_start(cyc == stray);
      if (done_s) begin
        dones++;
        dcyc = cyc;
        if (sb.size() > 0) check("rx_data", rx_s, sb.pop_front());
        break;
      end
      @(negedge Clock);
    end
    set_start(1'b0);
    check("done_seen", dones, 1);
  endtask

  initial begin
    Rst = 1'b1;
    din4 = 4'b1010; din8 = 8'h3C; din1 = 1'b1;
    repeat (2) @(negedge Clock);
    check("rst_shift", sh8, 0);
    check("rst_clockbr", ck8, 0);
    check("rst_update", up8, 0);
    check("rst_scanout", so8, 0);
    check("rst_mode", mc8, 0);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_rx8", rx8, 0);
    check("rst_rx4", rx4, 0);
    Rst = 1'b0;
    @(negedge Clock);

    sel = 4;
    run_op(8'h03, 1'b1, 0);
    check("l4_done_cycle", dcyc, 12);
    check("l4_dout", dout_s, 8'h03);
    check("l4_mode", mc_s, 1);
    check("l4_rises", rises, 5);
    check("l4_updates", upds, 1);
    @(negedge Clock);
    check("l4_done_drop", done_s, 0);
    check("l4_mode_hold", mc_s, 1);
    check("l4_rx_hold", rx_s, 8'h0A);

    sel = 8;
    run_op(8'hA5, 1'b1, 0);
    check("l8_done_cycle", dcyc, 20);
    check("l8_busy_cycles", busys, 20);
    check("l8_rises", rises, 9);
    check("l8_updates", upds, 1);
    check("l8_dout", dout_s, 8'hA5);
    check("l8_scanout_idle", so_bad, 0);
    @(negedge Clock);

    run_op(8'h5A, 1'b0, 5);
    check("stray_done_cycle", dcyc, 20);
    check("stray_dout", dout_s, 8'h5A);
    check("stray_mode", mc_s, 0);
    @(negedge Clock);
    check("stray_idle_busy", busy_s, 0);
    check("stray_idle_done", done_s, 0);
    run_op(8'hC3, 1'b1, 0);
    check("second_done_cycle", dcyc, 20);
    check("second_dout", dout_s, 8'hC3);
    @(negedge Clock);
    idle_busy = 0;
    repeat (3) begin
      if (busy_s || done_s) idle_busy++;
      @(negedge Clock);
    end
    check("no_queued_op", idle_busy, 0);

    saved = dout8;
    tx8 = 8'h0F; mreq8 = 1'b1;
    set_start(1'b1);
    @(negedge Clock);
    set_start(1'b0);
    repeat (8) @(negedge Clock);
    check("mid_in_shift", sh8, 1);
    Rst = 1'b1;
    #1;
    check("mid_shift", sh8, 0);
    check("mid_clockbr", ck8, 0);
    check("mid_update", up8, 0);
    check("mid_scanout", so8, 0);
    check("mid_mode", mc8, 0);
    check("mid_busy", busy8, 0);
    check("mid_done", done8, 0);
    check("mid_rx", rx8, 0);
    repeat (2) @(negedge Clock);
    Rst = 1'b0;
    @(negedge Clock);
    check("mid_no_update", dout8, saved);
    run_op(8'h81, 1'b1, 0);
    check("after_rst_cycle", dcyc, 20);
    check("after_rst_dout", dout_s, 8'h81);
    @(negedge Clock);

    sel = 1;
    run_op(8'h00, 1'b1, 0);
    check("l1_done_cycle", dcyc, 6);
    check("l1_dout", dout_s, 0);
    check("l1_rises", rises, 2);
    @(negedge Clock);

    sel = 8;
    din8 = 8'h96;
    run_op(8'hFF, 1'b1, 0);
    check("b2b_first_dout", dout_s, 8'hFF);
    check("b2b_first_so", so_bad, 0);
    @(negedge Clock);
    check("b2b_gap_scanout", so_s, 0);
    run_op(8'h00, 1'b0, 0);
    check("b2b_second_dout", dout_s, 8'h00);
    check("b2b_second_so", so_bad, 0);
    check("b2b_second_mode", mc_s, 0);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
